// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: captures packed BCD digits into a shadow register and
// scans them one digit per refresh slot onto a common-anode 7-segment display.
// Optional feature macro: BCD_SCAN_LZB_EN (leading-zero blanking).
module bcd_display_scanner #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic [2:0]            digit_idx,
   output logic                  err
);

   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   logic [PW-1:0]       presc;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow;
   logic                tick;
   logic [3:0]          cur_digit;
   logic                bad_any;
   logic                blank;
   logic [6:0]          seg_next;
   logic [DIGITS-1:0]   an_next;

   // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash
   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign tick = (presc == PRESC_LAST);

   // Select the digit under the current scan index and flag any invalid shadow digit
   always_comb begin
      cur_digit = 4'd0;
      bad_any   = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (IW'(k) == idx) cur_digit = shadow[4*k +: 4];
         if (shadow[4*k +: 4] > 4'd9) bad_any = 1'b1;
      end
   end

`ifdef BCD_SCAN_LZB_EN
   logic upper_zero;

   // Blank a non-least digit when it and every more significant digit are zero
   always_comb begin
      upper_zero = 1'b1;
      blank      = 1'b0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         upper_zero = upper_zero && (shadow[4*k +: 4] == 4'd0);
         if ((IW'(k) == idx) && (k > 0) && upper_zero) blank = 1'b1;
      end
   end
`else
   assign blank = 1'b0;
`endif

   // Next output values from the pre-edge index and shadow contents
   always_comb begin
      seg_next = blank ? 7'h7F : enc(cur_digit);
      an_next  = ~(DIGITS'(1) << idx);
   end

   // Prescaler, scan index and shadow capture; load and tick act independently
   always_ff @(posedge clk) begin
      if (!rst) begin
         presc  <= '0;
         idx    <= '0;
         shadow <= '0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
         if (load) shadow <= bcd_in;
      end
   end

   // Registered display drive, one cycle behind index/shadow changes
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg       <= 7'h7F;
         an        <= '1;
         digit_idx <= 3'd0;
         err       <= 1'b0;
      end else begin
         seg       <= seg_next;
         an        <= an_next;
         digit_idx <= 3'(idx);
         err       <= bad_any;
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (DIGITS=4, REFRESH_DIV=4).
module tb_bcd_display_scanner;

   localparam int D = 4;
   localparam int R = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [15:0]  bcd_in = 16'h0;
   logic [6:0]   seg;
   logic [3:0]   an;
   logic [2:0]   digit_idx;
   logic         err;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
      logic [2:0] idx;
      logic       err;
   } exp_t;

   exp_t        sb[$];
   int          m_presc = 0;
   int          m_idx = 0;
   logic [15:0] m_shadow = 16'h0;
   int          vectors = 0;
   int          miscompares = 0;

   bcd_display_scanner #(.DIGITS(D), .REFRESH_DIV(R)) dut (
      .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
      .seg(seg), .an(an), .digit_idx(digit_idx), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] t [0:9];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return (d > 4'd9) ? 7'h3F : t[d];
   endfunction

   // One clock: drive inputs, push expectation from model, compare after the edge
   task automatic step(input logic r, input logic l, input logic [15:0] d);
      exp_t       e;
      logic [3:0] dg;
      @(negedge clk);
      rst = r; load = l; bcd_in = d;
      if (!r) begin
         e.seg = 7'h7F; e.an = 4'hF; e.idx = 3'd0; e.err = 1'b0;
      end else begin
         dg    = m_shadow[4*m_idx +: 4];
         e.seg = seg_of(dg);
`ifdef BCD_SCAN_LZB_EN
         if (m_idx > 0 && (m_shadow >> (4*m_idx)) == 16'h0) e.seg = 7'h7F;
`endif
         e.an  = ~(4'b0001 << m_idx);
         e.idx = 3'(m_idx);
         e.err = 1'b0;
         for (int k = 0; k < D; k++)
            if (m_shadow[4*k +: 4] > 4'd9) e.err = 1'b1;
      end
      sb.push_back(e);
      if (!r) begin
         m_presc = 0; m_idx = 0; m_shadow = 16'h0;
      end else begin
         if (l) m_shadow = d;
         if (m_presc == R-1) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % D;
         end else begin
            m_presc++;
         end
      end
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("seg", 32'(seg), 32'(e.seg));
         check("an", 32'(an), 32'(e.an));
         check("digit_idx", 32'(digit_idx), 32'(e.idx));
         check("err", 32'(err), 32'(e.err));
         if (r) check("onehot_an", 32'($countones(~an)), 32'd1);
      end
   endtask

   initial begin
      int guard;
      // Reset held three cycles, then release
      repeat (3) step(1'b0, 1'b0, 16'h0);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_an", 32'(an), 32'hF);
      step(1'b1, 1'b0, 16'h0);
      check("first_an", 32'(an), 32'hE);
      check("first_seg", 32'(seg), 32'h40);

      // Normal scan of 1234
      step(1'b1, 1'b1, 16'h1234);
      repeat (20) step(1'b1, 1'b0, 16'h0);

      // Invalid digit raises err a cycle after load, clears on valid load
      step(1'b1, 1'b1, 16'h00A5);
      step(1'b1, 1'b0, 16'h0);
      check("err_set", 32'(err), 32'd1);
      repeat (16) step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 16'h0005);
      step(1'b1, 1'b0, 16'h0);
      check("err_clr", 32'(err), 32'd0);

      // Load on the same edge as a tick
      guard = 0;
      while (m_presc != R-1 && guard < 8) begin
         step(1'b1, 1'b0, 16'h0);
         guard++;
      end
      check("tick_align", 32'(m_presc), 32'(R-1));
      step(1'b1, 1'b1, 16'h5678);
      repeat (6) step(1'b1, 1'b0, 16'h0);

      // Reset mid-scan at idx=2, prescaler=2
      guard = 0;
      while (!(m_idx == 2 && m_presc == 2) && guard < 40) begin
         step(1'b1, 1'b0, 16'h0);
         guard++;
      end
      check("mid_align", 32'(m_idx*4 + m_presc), 32'd10);
      step(1'b0, 1'b0, 16'h0);
      check("mid_rst_an", 32'(an), 32'hF);
      repeat (2*R*D) step(1'b1, 1'b0, 16'h0);

      // Leading zeros
      step(1'b1, 1'b1, 16'h0070);
      repeat (20) step(1'b1, 1'b0, 16'h0);

      // Random loads, data and occasional resets
      repeat (300) begin
         step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
              16'($urandom()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
